// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-stage definitions: datapath widths, reset/NOP constants and
// the queue entry layout used by riscv_fetch and its queue.
package riscv_fetch_pkg;

  localparam int XLEN          = 32;
  localparam int IMEM_ADDR_BIT = 12;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Sequential PC step; wraps modulo 2^XLEN by construction.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/riscv_fetch_queue.sv
// Generic 2-entry FIFO with flush. The head is held in its own register so
// the outputs never depend combinationally on the write data.
module riscv_fetch_queue #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [2];
  logic             wptr;
  logic             rptr;
  logic             do_push;
  logic             do_pop;
  logic [1:0]       next_count;
  logic             next_wptr;
  logic             next_rptr;

  always_comb begin
    do_push    = push & ~flush & ((count != 2'd2) | pop);
    do_pop     = pop & (count != 2'd0);
    next_count = count + {1'b0, do_push} - {1'b0, do_pop};
    next_wptr  = do_push ? ~wptr : wptr;
    next_rptr  = do_pop ? ~rptr : rptr;
    if (flush) begin
      next_count = 2'd0;
      next_wptr  = 1'b0;
      next_rptr  = 1'b0;
    end
  end

  // Head register tracks the entry at the next read pointer; it holds its
  // value whenever the queue becomes empty (including reset and flush).
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
    end else begin
      if (do_push)
        mem[wptr] <= din;
      count <= next_count;
      wptr  <= next_wptr;
      rptr  <= next_rptr;
      if (next_count != 2'd0)
        head <= (do_push && (wptr == next_rptr)) ? din : mem[next_rptr];
    end
  end

endmodule

// File: rtl/riscv_fetch.sv
// Instruction-fetch stage: owns the PC, addresses the async-read imem and
// queues {instr, pc} pairs for decode; redirects flush the queue.
module riscv_fetch
  import riscv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              QDEPTH   = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  output logic [IMEM_ADDR_BIT-3:0] o_imem_addr,
  input  logic [XLEN-1:0]          i_imem_data,
  input  logic                     i_redirect,
  input  logic [XLEN-1:0]          i_redirect_pc,
  output logic                     o_if_valid,
  input  logic                     i_if_ready,
  output logic [XLEN-1:0]          o_if_instr,
  output logic [XLEN-1:0]          o_if_pc,
  output logic [XLEN-1:0]          o_if_pc4,
  output logic                     o_fetch_err
);

  logic [XLEN-1:0] pc;
  logic [1:0]      count;
  logic            push;
  logic            pop;
  fetch_entry_t    din;
  fetch_entry_t    head;

  assign o_imem_addr = pc[IMEM_ADDR_BIT-1:2];
  assign o_if_valid  = (count != 2'd0);
  assign pop         = o_if_valid & i_if_ready;
  assign push        = ~i_redirect & ((count < 2'(QDEPTH)) | pop);

  assign din.instr = i_imem_data;
  assign din.pc    = pc;

  assign o_if_instr = head.instr;
  assign o_if_pc    = head.pc;
  assign o_if_pc4   = pc_plus4(head.pc);

  // Reset beats redirect, redirect beats sequential advance; the low PC bits
  // are forced to zero so a misaligned target still fetches aligned words.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc          <= {RESET_PC[XLEN-1:2], 2'b00};
      o_fetch_err <= 1'b0;
    end else if (i_redirect) begin
      pc <= {i_redirect_pc[XLEN-1:2], 2'b00};
      if (i_redirect_pc[1:0] != 2'b00)
        o_fetch_err <= 1'b1;
    end else if (push) begin
      pc <= pc_plus4(pc);
    end
  end

  riscv_fetch_queue #(
    .WIDTH($bits(fetch_entry_t))
  ) u_queue (
    .clk   (i_clk),
    .rst   (i_rst),
    .flush (i_redirect),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .count (count),
    .head  (head)
  );

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch: reset, backpressure, full-queue streaming,
// redirects (aligned, misaligned, wrapping) and reset-over-redirect priority.
module tb_riscv_fetch;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [9:0]  o_imem_addr;
  logic [31:0] i_imem_data;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_if_valid;
  logic        i_if_ready;
  logic [31:0] o_if_instr;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_pc4;
  logic        o_fetch_err;

  logic [31:0] imem [0:1023];
  int          checks   = 0;
  int          failures = 0;

  always #5 i_clk = ~i_clk;

  assign i_imem_data = imem[o_imem_addr];

  riscv_fetch dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .o_imem_addr   (o_imem_addr),
    .i_imem_data   (i_imem_data),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_if_valid    (o_if_valid),
    .i_if_ready    (i_if_ready),
    .o_if_instr    (o_if_instr),
    .o_if_pc       (o_if_pc),
    .o_if_pc4      (o_if_pc4),
    .o_fetch_err   (o_fetch_err)
  );

  // Drive inputs, clock one edge, then settle 1ns past it before sampling.
  task automatic applyStimulus(input logic rst, input logic redir,
                               input logic [31:0] rpc, input logic ready);
    i_rst         = rst;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    i_if_ready    = ready;
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++)
      imem[i] = 32'hA500_0000 | i;
    imem[0] = 32'h0000_0013;
    imem[1] = 32'h0010_0093;

    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("rst_valid", {31'b0, o_if_valid}, 32'h0);
    checkOutput("rst_addr", {22'b0, o_imem_addr}, 32'h0);
    checkOutput("rst_err", {31'b0, o_fetch_err}, 32'h0);

    $display("[TB] reset release");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("rel_valid", {31'b0, o_if_valid}, 32'h1);
    checkOutput("rel_pc", o_if_pc, 32'h0);
    checkOutput("rel_instr", o_if_instr, 32'h0000_0013);
    checkOutput("rel_pc4", o_if_pc4, 32'h4);
    checkOutput("rel_addr", {22'b0, o_imem_addr}, 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("second_pc", o_if_pc, 32'h4);
    checkOutput("second_instr", o_if_instr, 32'h0010_0093);
    checkOutput("second_pc4", o_if_pc4, 32'h8);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("bp2_addr", {22'b0, o_imem_addr}, 32'h2);
    checkOutput("bp2_pc", o_if_pc, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("bp5_addr", {22'b0, o_imem_addr}, 32'h2);
    checkOutput("bp5_valid", {31'b0, o_if_valid}, 32'h1);
    checkOutput("bp5_pc", o_if_pc, 32'h0);
    checkOutput("bp5_instr", o_if_instr, 32'h0000_0013);

    // Full queue with ready: pop and push together each cycle.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("full1_pc", o_if_pc, 32'h4);
    checkOutput("full1_addr", {22'b0, o_imem_addr}, 32'h3);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("full2_pc", o_if_pc, 32'h8);
    checkOutput("full2_instr", o_if_instr, 32'hA500_0002);
    checkOutput("full2_addr", {22'b0, o_imem_addr}, 32'h4);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("full3_pc", o_if_pc, 32'hC);
    checkOutput("full3_valid", {31'b0, o_if_valid}, 32'h1);

    $display("[TB] redirect");
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b1);
    checkOutput("redir_valid", {31'b0, o_if_valid}, 32'h0);
    checkOutput("redir_addr", {22'b0, o_imem_addr}, 32'h10);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("redir_tgt_valid", {31'b0, o_if_valid}, 32'h1);
    checkOutput("redir_tgt_pc", o_if_pc, 32'h40);
    checkOutput("redir_tgt_instr", o_if_instr, 32'hA500_0010);
    checkOutput("redir_noerr", {31'b0, o_fetch_err}, 32'h0);

    // Back-to-back redirects: the second target wins.
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h200, 1'b1);
    checkOutput("b2b_addr", {22'b0, o_imem_addr}, 32'h80);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("b2b_pc", o_if_pc, 32'h200);

    $display("[TB] misaligned redirect");
    applyStimulus(1'b0, 1'b1, 32'h42, 1'b1);
    checkOutput("mis_err", {31'b0, o_fetch_err}, 32'h1);
    checkOutput("mis_addr", {22'b0, o_imem_addr}, 32'h10);
    checkOutput("mis_valid", {31'b0, o_if_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("mis_pc", o_if_pc, 32'h40);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("mis_sticky", {31'b0, o_fetch_err}, 32'h1);
    checkOutput("mis_seq_pc", o_if_pc, 32'h48);

    $display("[TB] wrap");
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    checkOutput("wrap_addr", {22'b0, o_imem_addr}, 32'h3FF);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("wrap_pc", o_if_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_pc4", o_if_pc4, 32'h0);
    checkOutput("wrap_instr", o_if_instr, 32'hA500_03FF);
    checkOutput("wrap_next_addr", {22'b0, o_imem_addr}, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h1004, 1'b1);
    checkOutput("hi_addr", {22'b0, o_imem_addr}, 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("hi_pc", o_if_pc, 32'h1004);
    checkOutput("hi_instr", o_if_instr, 32'h0010_0093);

    $display("[TB] reset over redirect");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("pre_rst_err", {31'b0, o_fetch_err}, 32'h1);
    applyStimulus(1'b1, 1'b1, 32'h80, 1'b1);
    checkOutput("rr_valid", {31'b0, o_if_valid}, 32'h0);
    checkOutput("rr_addr", {22'b0, o_imem_addr}, 32'h0);
    checkOutput("rr_err", {31'b0, o_fetch_err}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("rr_pc", o_if_pc, 32'h0);
    checkOutput("rr_instr", o_if_instr, 32'h0000_0013);
    checkOutput("rr_valid2", {31'b0, o_if_valid}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
